// File: rtl/spi_pkg.sv
// Shared SPI-side definitions: controller state encoding and command byte layout.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR_DATA = 3'd2,
        RD_WAIT = 3'd3,
        RD_DATA = 3'd4
    } spi_state_e;

    localparam int CMD_BYTE_WIDTH = 8;
    localparam int CMD_ADDR_WIDTH = 7;
    localparam int CMD_RD_BIT     = 7;

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for raw SPI chip select, with rising/falling edge detect.
module spi_cs_sync (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_CS_n,
    output logic o_CS_s,
    output logic o_Rise,
    output logic o_Fall
);

    logic cs_meta;
    logic cs_q;

    // Reset to the deselected level so leaving reset never looks like an edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cs_meta <= 1'b1;
            o_CS_s  <= 1'b1;
            cs_q    <= 1'b1;
        end else begin
            cs_meta <= i_CS_n;
            o_CS_s  <= cs_meta;
            cs_q    <= o_CS_s;
        end
    end

    assign o_Rise = o_CS_s & ~cs_q;
    assign o_Fall = ~o_CS_s & cs_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Decodes the SPI command byte and sequences auto-incrementing register
// writes/reads, feeding read data back to the slave's TX byte register.
//
// state   | meaning
// IDLE    | CS deselected, waiting for the select edge
// CMD     | selected, waiting for the command byte
// WR_DATA | each received byte is written to the current address
// RD_WAIT | fetch issued, waiting for register read data
// RD_DATA | read byte loaded to TX, waiting for the byte boundary
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int                          ADDR_WIDTH  = 7,
    parameter logic [CMD_BYTE_WIDTH-1:0]   STATUS_BYTE = 8'hA5
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic                      i_SPI_CS_n,
    input  logic                      i_RX_DV,
    input  logic [CMD_BYTE_WIDTH-1:0] i_RX_Byte,
    output logic                      o_TX_DV,
    output logic [CMD_BYTE_WIDTH-1:0] o_TX_Byte,
    output logic [ADDR_WIDTH-1:0]     o_Reg_Addr,
    output logic                      o_Reg_Wr_En,
    output logic [CMD_BYTE_WIDTH-1:0] o_Reg_Wr_Data,
    output logic                      o_Reg_Rd_En,
    input  logic                      i_Reg_Rd_Valid,
    input  logic [CMD_BYTE_WIDTH-1:0] i_Reg_Rd_Data,
    output logic                      o_Busy,
    output logic                      o_Err_Overrun
);

    spi_state_e              state;
    logic                    cs_s;
    logic                    cs_rise;
    logic                    cs_fall;
    logic                    init_load;
    logic                    ovr_hit;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [ADDR_WIDTH-1:0]   addr_step;

    spi_cs_sync u_cs_sync (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_CS_n (i_SPI_CS_n),
        .o_CS_s (cs_s),
        .o_Rise (cs_rise),
        .o_Fall (cs_fall)
    );

    assign o_Busy   = ~cs_s;
    assign cmd_addr = ADDR_WIDTH'(i_RX_Byte[CMD_ADDR_WIDTH-1:0]);
    assign ovr_hit  = (state == RD_WAIT) && i_RX_DV;

    // The address steps one cycle after each strobe; an overrun byte also
    // consumes an address, and both can land on the same edge.
    always_comb begin
        addr_step = ADDR_WIDTH'(o_Reg_Wr_En | o_Reg_Rd_En) + ADDR_WIDTH'(ovr_hit);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state         <= IDLE;
            init_load     <= 1'b1;
            o_TX_DV       <= 1'b0;
            o_TX_Byte     <= STATUS_BYTE;
            o_Reg_Addr    <= '0;
            o_Reg_Wr_En   <= 1'b0;
            o_Reg_Wr_Data <= '0;
            o_Reg_Rd_En   <= 1'b0;
            o_Err_Overrun <= 1'b0;
        end else begin
            init_load   <= 1'b0;
            o_TX_DV     <= 1'b0;
            o_Reg_Wr_En <= 1'b0;
            o_Reg_Rd_En <= 1'b0;
            o_Reg_Addr  <= o_Reg_Addr + addr_step;

            if (init_load) begin
                o_TX_DV   <= 1'b1;
                o_TX_Byte <= STATUS_BYTE;
            end

            case (state)
                // cs_s can only drop in IDLE through a detected falling edge
                IDLE: begin
                    if (cs_fall) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (i_RX_DV) begin
                        o_Reg_Addr <= cmd_addr;
                        if (i_RX_Byte[CMD_RD_BIT]) begin
                            o_Reg_Rd_En <= 1'b1;
                            state       <= RD_WAIT;
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (i_RX_DV) begin
                        o_Reg_Wr_En   <= 1'b1;
                        o_Reg_Wr_Data <= i_RX_Byte;
                    end
                end
                RD_WAIT: begin
                    if (i_RX_DV) begin
                        o_Err_Overrun <= 1'b1;
                    end
                    if (i_Reg_Rd_Valid) begin
                        o_TX_DV   <= 1'b1;
                        o_TX_Byte <= i_Reg_Rd_Data;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (i_RX_DV) begin
                        o_Reg_Rd_En <= 1'b1;
                        state       <= RD_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase

            // Deselect wins over everything except a write already accepted
            // this cycle; any read in flight is abandoned.
            if (cs_rise) begin
                state       <= IDLE;
                o_Reg_Rd_En <= 1'b0;
                o_TX_DV     <= 1'b1;
                o_TX_Byte   <= STATUS_BYTE;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with a scoreboard of expected register
// writes, read fetches and TX loads, compared as the strobes appear.
module tb_spi_reg_ctrl;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       cs_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [6:0] reg_addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       ovr;

    int errors = 0;
    int checks = 0;
    int rd_lat = 1;

    logic [7:0] mem [128];
    wr_t        exp_wr[$];
    logic [6:0] exp_rd[$];
    logic [7:0] exp_tx[$];

    spi_reg_ctrl dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_SPI_CS_n     (cs_n),
        .i_RX_DV        (rx_dv),
        .i_RX_Byte      (rx_byte),
        .o_TX_DV        (tx_dv),
        .o_TX_Byte      (tx_byte),
        .o_Reg_Addr     (reg_addr),
        .o_Reg_Wr_En    (wr_en),
        .o_Reg_Wr_Data  (wr_data),
        .o_Reg_Rd_En    (rd_en),
        .i_Reg_Rd_Valid (rd_valid),
        .i_Reg_Rd_Data  (rd_data),
        .o_Busy         (busy),
        .o_Err_Overrun  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic cs_low();
        @(posedge clk); #1;
        cs_n = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic cs_high();
        @(posedge clk); #1;
        cs_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    // Scoreboard: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (wr_en) begin
            checks++;
            assert (exp_wr.size() > 0) else begin
                errors++;
                $error("FAIL wr_unexpected got addr=%0h data=%0h exp none", reg_addr, wr_data);
            end
            if (exp_wr.size() > 0) begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        if (rd_en) begin
            checks++;
            assert (exp_rd.size() > 0) else begin
                errors++;
                $error("FAIL rd_unexpected got addr=%0h exp none", reg_addr);
            end
            if (exp_rd.size() > 0) check("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
        end
        if (tx_dv) begin
            checks++;
            assert (exp_tx.size() > 0) else begin
                errors++;
                $error("FAIL tx_unexpected got byte=%0h exp none", tx_byte);
            end
            if (exp_tx.size() > 0) check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
        end
    end

    // Register-file model: answers each fetch rd_lat cycles later.
    initial begin
        logic [7:0] d;
        rd_valid = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_en) begin
                d = mem[reg_addr];
                repeat (rd_lat) @(posedge clk);
                #1;
                rd_valid = 1'b1;
                rd_data  = d;
                @(posedge clk); #1;
                rd_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'((i * 13 + 7) ^ 8'h3C);
        rst     = 1'b1;
        cs_n    = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_dv",   32'(tx_dv),    0);
        check("rst_tx_byte", 32'(tx_byte),  32'h A5);
        check("rst_wr_en",   32'(wr_en),    0);
        check("rst_rd_en",   32'(rd_en),    0);
        check("rst_addr",    32'(reg_addr), 0);
        check("rst_wr_data", 32'(wr_data),  0);
        check("rst_busy",    32'(busy),     0);
        check("rst_ovr",     32'(ovr),      0);
        exp_tx.push_back(8'hA5);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Write burst
        cs_low();
        check("busy_low", 32'(busy), 1);
        exp_wr.push_back('{7'h05, 8'h11});
        exp_wr.push_back('{7'h06, 8'h22});
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        exp_tx.push_back(8'hA5);
        cs_high();
        check("busy_high", 32'(busy), 0);

        // Read burst, data one cycle after each fetch
        rd_lat = 1;
        cs_low();
        exp_rd.push_back(7'h05);
        exp_tx.push_back(mem[5]);
        send_byte(8'h85);
        exp_rd.push_back(7'h06);
        exp_tx.push_back(mem[6]);
        send_byte(8'h00);
        exp_tx.push_back(8'hA5);
        cs_high();
        check("no_ovr_read", 32'(ovr), 0);

        // Address wrap
        cs_low();
        exp_wr.push_back('{7'h7F, 8'hAA});
        exp_wr.push_back('{7'h00, 8'hBB});
        send_byte(8'h7F);
        send_byte(8'hAA);
        send_byte(8'hBB);
        exp_tx.push_back(8'hA5);
        cs_high();

        // Empty CS pulse: status reload only
        cs_low();
        exp_tx.push_back(8'hA5);
        cs_high();

        // Overrun: next byte arrives before read data
        rd_lat = 30;
        cs_low();
        exp_rd.push_back(7'h10);
        exp_tx.push_back(mem[16]);
        send_byte(8'h90);
        send_byte(8'h00);
        check("ovr_set", 32'(ovr), 1);
        repeat (25) @(posedge clk);
        exp_tx.push_back(8'hA5);
        cs_high();
        cs_low();
        exp_wr.push_back('{7'h20, 8'h33});
        send_byte(8'h20);
        send_byte(8'h33);
        exp_tx.push_back(8'hA5);
        cs_high();
        check("ovr_sticky", 32'(ovr), 1);

        // CS abort while waiting for read data
        rd_lat = 20;
        cs_low();
        exp_rd.push_back(7'h30);
        send_byte(8'hB0);
        exp_tx.push_back(8'hA5);
        @(posedge clk); #1;
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_tx_dv_3cyc", 32'(tx_dv), 1);
        check("abort_busy", 32'(busy), 0);
        repeat (30) @(posedge clk);
        check("abort_tx_queue", 32'(exp_tx.size()), 0);

        // Reset in the middle of a write burst
        rd_lat = 1;
        cs_low();
        exp_wr.push_back('{7'h40, 8'h44});
        send_byte(8'h40);
        send_byte(8'h44);
        @(posedge clk); #1;
        rst     = 1'b1;
        rx_dv   = 1'b1;
        rx_byte = 8'h55;
        cs_n    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_wr_en", 32'(wr_en),    0);
        check("mid_rst_addr",  32'(reg_addr), 0);
        check("mid_rst_busy",  32'(busy),     0);
        check("mid_rst_ovr",   32'(ovr),      0);
        check("mid_rst_txb",   32'(tx_byte),  32'h A5);
        @(posedge clk); #1;
        rx_dv = 1'b0;
        exp_tx.push_back(8'hA5);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Data byte coincident with the synchronized CS rise
        cs_low();
        send_byte(8'h60);
        exp_wr.push_back('{7'h60, 8'h66});
        exp_tx.push_back(8'hA5);
        @(posedge clk); #1;
        cs_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rx_dv   = 1'b1;
        rx_byte = 8'h66;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        repeat (6) @(posedge clk);

        check("end_wr_queue", 32'(exp_wr.size()), 0);
        check("end_rd_queue", 32'(exp_rd.size()), 0);
        check("end_tx_queue", 32'(exp_tx.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command/register-access controller for the SPI slave. It consumes the slave's received-byte stream, decodes a one-byte command header, and sequences auto-incrementing register writes or reads on a simple register bus. For reads it loads the slave's TX byte register so that each data byte is shifted out on MISO. It sits between the SPI slave's i_Clk-domain byte interface and the design's control/status register file.

## Interface
Parameters:
- ADDR_WIDTH, 7: register address width; the command carries 7 address bits, and the upper bits are zero-extended when ADDR_WIDTH > 7.
- STATUS_BYTE, 8'hA5: byte loaded to TX when idle; it is shifted out during the command byte.

Ports:
- i_Clk  in  1  system clock; one clock; same clock as the SPI slave's i_Clk.
- i_Rst  in  1  reset; synchronous, active-high.
- i_SPI_CS_n  in  1  raw SPI chip select; synchronized internally.
- i_RX_DV  in  1  one-cycle pulse from the slave: a byte was received.
- i_RX_Byte  in  8  received byte, valid with i_RX_DV.
- o_TX_DV  out  1  one-cycle pulse that loads o_TX_Byte into the slave.
- o_TX_Byte  out  8  byte to be shifted out on MISO.
- o_Reg_Addr  out  ADDR_WIDTH  register address.
- o_Reg_Wr_En  out  1  one-cycle write strobe.
- o_Reg_Wr_Data  out  8  write data.
- o_Reg_Rd_En  out  1  one-cycle read request.
- i_Reg_Rd_Valid  in  1  read data valid; arrives 1..N cycles after o_Reg_Rd_En.
- i_Reg_Rd_Data  in  8  read data, valid with i_Reg_Rd_Valid.
- o_Busy  out  1  a transaction is active (synchronized CS is low).
- o_Err_Overrun  out  1  sticky flag: read data was late. Cleared only by reset.

## Operation
Protocol:
- Byte 0 is the command: bit7 = 1 selects read, 0 selects write; bits 6:0 are the start address.
- Every following byte is one data byte. The address auto-increments and wraps from 2^ADDR_WIDTH-1 to 0.

CS handling:
- i_SPI_CS_n passes through a 2-flop synchronizer; the result is cs_s.
- A rising edge of cs_s ends the transaction.
- o_Busy = ~cs_s.

FSM states and transitions:
- IDLE: waits for cs_s low, then goes to CMD.
- CMD: on i_RX_DV, latches the address.
  - If bit7 = 0: go to WR_DATA.
  - If bit7 = 1: issue the first fetch and go to RD_WAIT.
- WR_DATA: each i_RX_DV produces a write strobe with the current address and i_RX_Byte, then increments the address.
- RD_WAIT: waits for i_Reg_Rd_Valid, then issues o_TX_DV with i_Reg_Rd_Data and goes to RD_DATA.
- RD_DATA: each i_RX_DV (the end of a data byte) issues the fetch for the next address and goes to RD_WAIT.
  - Received MOSI bytes are ignored during reads.
- From any state, a cs_s rising edge returns the FSM to IDLE.
  - A pending read is dropped; a late i_Reg_Rd_Valid is ignored.
  - o_TX_DV is pulsed with STATUS_BYTE.

Overrun:
- An i_RX_DV arriving while in RD_WAIT sets o_Err_Overrun.
- That byte is still counted and the address still increments; the late data is still loaded when it arrives.

Boundary rules:
- i_RX_DV in the same cycle as the cs_s rise is processed first: a write is still performed, then the FSM goes to IDLE.
- A CS pulse with no bytes received performs no register access.

Reset:
- FSM returns to IDLE and the address goes to 0.
- Output reset values:
  - o_TX_DV, o_Reg_Wr_En, o_Reg_Rd_En, o_Err_Overrun = 0.
  - o_TX_Byte = STATUS_BYTE; o_Reg_Wr_Data = 0; o_Reg_Addr = 0.
  - o_Busy = 0; the synchronizer resets to CS high.
- On the first cycle after reset, o_TX_DV pulses once to load STATUS_BYTE.
- Reset asserted mid-transaction aborts the transaction with no further strobes.

## Timing
All latencies are measured from the i_RX_DV cycle, t:
- Write: o_Reg_Wr_En, o_Reg_Addr and o_Reg_Wr_Data are valid at t+1; the address increments at t+2.
- Read fetch: o_Reg_Rd_En and o_Reg_Addr are valid at t+1.
  - i_Reg_Rd_Valid arrives at cycle v.
  - o_TX_DV and o_TX_Byte are valid at v+1.

Other timing rules:
- All strobes are single-cycle and registered; no output is combinational from any input.
- CS deassert to return to IDLE: 3 cycles, made up of 2 synchronizer cycles and 1 edge-detect cycle.
- Throughput: one byte per 8 SPI clocks. With i_Clk ≥ 4× SCK, read latency must stay below about 24 i_Clk cycles to avoid overrun.

## Structure
- The shared package spi_pkg holds:
  - the FSM state enum: IDLE, CMD, WR_DATA, RD_WAIT, RD_DATA;
  - CMD_RD_BIT = 7;
  - the command field widths.
- The sub-module spi_cs_sync contains the 2-flop synchronizer and rising/falling edge detect. It is reused by other SPI-side blocks.

## Test plan
- Write burst: CS low; bytes 0x05, 0x11, 0x22 → Wr_En at addr 5 with data 0x11, then addr 6 with data 0x22; no Rd_En.
- Read burst: cmd 0x85, register returns data 1 cycle after request → Rd_En at addr 5, then TX_DV with reg[5]. After the next RX_DV: Rd_En at addr 6, then TX_DV with reg[6].
- Wrap-around: write cmd 0x7F followed by 2 data bytes → writes at addr 0x7F then 0x00.
- Overrun: read with Rd_Valid held off past the next RX_DV → o_Err_Overrun = 1, and it stays 1 across a later CS cycle until reset.
- CS abort: CS rises while in RD_WAIT → FSM goes to IDLE within 3 cycles; TX_DV carries 0xA5; a late Rd_Valid causes no TX_DV.
- Reset mid-write and simultaneous events: i_Rst pulsed during a burst → all outputs at reset values, no strobes. Separately, i_RX_DV coincident with a CS rise → the write is still performed.
